// File: rtl/uart_tarih_gonderici.sv
// ============================================================================
// Module  : uart_tarih_gonderici
// Purpose : On a received command byte, snapshots the live date/time and
//           sends "DD.MM.YYYY HH:MM:SS" (optionally CR LF) over a UART TX port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tarih_gonderici #(
    parameter logic [7:0] KOMUT_KARAKTERI = 8'h54,
    parameter int         SATIR_SONU      = 1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    input  logic [4:0]  gun,
    input  logic [3:0]  ay,
    input  logic [11:0] yil,
    input  logic [4:0]  saat,
    input  logic [5:0]  dakika,
    input  logic [5:0]  saniye,
    input  logic        uart_tx_busy,
    output logic        uart_tx_en,
    output logic [7:0]  uart_tx_data,
    output logic        mesgul,
    output logic        gonderim_bitti
);

    localparam int unsigned MSG_LEN  = (SATIR_SONU != 0) ? 21 : 19;
    localparam logic [4:0]  LAST_IDX = 5'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        advance;
    logic        finish;
    logic        send_strobe;
    logic [4:0]  idx;

    logic [4:0]  snap_gun;
    logic [3:0]  snap_ay;
    logic [11:0] snap_yil;
    logic [4:0]  snap_saat;
    logic [5:0]  snap_dakika;
    logic [5:0]  snap_saniye;

    logic [7:0]  char_buf [0:20];

    function automatic logic [7:0] ascii_digit(input logic [6:0] d);
        return 8'h30 + {1'b0, d};
    endfunction

    function automatic logic [7:0] tens_char(input logic [6:0] v);
        return ascii_digit(v / 7'd10);
    endfunction

    function automatic logic [7:0] units_char(input logic [6:0] v);
        return ascii_digit(v % 7'd10);
    endfunction

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        advance     = 1'b0;
        finish      = 1'b0;
        send_strobe = 1'b0;
        case (state)
            S_IDLE: begin
                // The cycle that reports completion never starts a new report.
                if (uart_rx_valid && (uart_rx_data == KOMUT_KARAKTERI) && !gonderim_bitti) begin
                    accept     = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = S_SEND;
            end
            S_SEND: begin
                if (!uart_tx_busy) begin
                    send_strobe = 1'b1;
                    state_next  = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (uart_tx_busy) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (idx == LAST_IDX) begin
                        finish     = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        advance    = 1'b1;
                        state_next = S_SEND;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            idx <= 5'd0;
        end else if (accept || finish) begin
            idx <= 5'd0;
        end else if (advance) begin
            idx <= idx + 5'd1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            gonderim_bitti <= 1'b0;
        end else begin
            gonderim_bitti <= finish;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            snap_gun    <= 5'd0;
            snap_ay     <= 4'd0;
            snap_yil    <= 12'd0;
            snap_saat   <= 5'd0;
            snap_dakika <= 6'd0;
            snap_saniye <= 6'd0;
        end else if (accept) begin
            snap_gun    <= gun;
            snap_ay     <= ay;
            snap_yil    <= yil;
            snap_saat   <= saat;
            snap_dakika <= dakika;
            snap_saniye <= saniye;
        end
    end

    // Character buffer is filled once in LOAD and read by index while sending.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 21; i++) begin
                char_buf[i] <= 8'h00;
            end
        end else if (state == S_LOAD) begin
            char_buf[0]  <= tens_char({2'b00, snap_gun});
            char_buf[1]  <= units_char({2'b00, snap_gun});
            char_buf[2]  <= 8'h2E;
            char_buf[3]  <= tens_char({3'b000, snap_ay});
            char_buf[4]  <= units_char({3'b000, snap_ay});
            char_buf[5]  <= 8'h2E;
            char_buf[6]  <= ascii_digit(7'(snap_yil / 12'd1000));
            char_buf[7]  <= ascii_digit(7'((snap_yil / 12'd100) % 12'd10));
            char_buf[8]  <= ascii_digit(7'((snap_yil / 12'd10) % 12'd10));
            char_buf[9]  <= ascii_digit(7'(snap_yil % 12'd10));
            char_buf[10] <= 8'h20;
            char_buf[11] <= tens_char({2'b00, snap_saat});
            char_buf[12] <= units_char({2'b00, snap_saat});
            char_buf[13] <= 8'h3A;
            char_buf[14] <= tens_char({1'b0, snap_dakika});
            char_buf[15] <= units_char({1'b0, snap_dakika});
            char_buf[16] <= 8'h3A;
            char_buf[17] <= tens_char({1'b0, snap_saniye});
            char_buf[18] <= units_char({1'b0, snap_saniye});
            char_buf[19] <= (SATIR_SONU != 0) ? 8'h0D : 8'h00;
            char_buf[20] <= (SATIR_SONU != 0) ? 8'h0A : 8'h00;
        end
    end

    assign uart_tx_en   = send_strobe;
    assign uart_tx_data = char_buf[idx];
    assign mesgul       = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tarih_gonderici.sv
// ============================================================================
// Module  : tb_uart_tarih_gonderici
// Purpose : Scoreboard bench for uart_tarih_gonderici (with and without CR LF).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tarih_gonderici;

    logic        CLK = 1'b0;
    logic        reset;
    logic        uart_rx_valid;
    logic        uart_rx_valid2;
    logic [7:0]  uart_rx_data;
    logic [4:0]  gun;
    logic [3:0]  ay;
    logic [11:0] yil;
    logic [4:0]  saat;
    logic [5:0]  dakika;
    logic [5:0]  saniye;

    logic        uart_tx_busy,  uart_tx_busy2;
    logic        uart_tx_en,    uart_tx_en2;
    logic [7:0]  uart_tx_data,  uart_tx_data2;
    logic        mesgul,        mesgul2;
    logic        gonderim_bitti, gonderim_bitti2;

    int checks = 0;
    int failures = 0;
    int strobes = 0, strobes2 = 0;
    int bitti_cnt = 0, bitti_cnt2 = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_q2[$];
    int bcnt = 0, bcnt2 = 0;

    always #5 CLK = ~CLK;

    uart_tarih_gonderici dut (
        .CLK(CLK), .reset(reset),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
        .gun(gun), .ay(ay), .yil(yil), .saat(saat), .dakika(dakika), .saniye(saniye),
        .uart_tx_busy(uart_tx_busy), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
        .mesgul(mesgul), .gonderim_bitti(gonderim_bitti)
    );

    uart_tarih_gonderici #(.KOMUT_KARAKTERI(8'h54), .SATIR_SONU(0)) dut19 (
        .CLK(CLK), .reset(reset),
        .uart_rx_valid(uart_rx_valid2), .uart_rx_data(uart_rx_data),
        .gun(gun), .ay(ay), .yil(yil), .saat(saat), .dakika(dakika), .saniye(saniye),
        .uart_tx_busy(uart_tx_busy2), .uart_tx_en(uart_tx_en2), .uart_tx_data(uart_tx_data2),
        .mesgul(mesgul2), .gonderim_bitti(gonderim_bitti2)
    );

    // Transmitter models: busy rises one cycle after a strobe and lasts 10 cycles.
    always @(posedge CLK) begin
        if (reset) begin
            bcnt <= 0; uart_tx_busy <= 1'b0;
        end else if (uart_tx_en) begin
            bcnt <= 9; uart_tx_busy <= 1'b1;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end else begin
            uart_tx_busy <= 1'b0;
        end
    end

    always @(posedge CLK) begin
        if (reset) begin
            bcnt2 <= 0; uart_tx_busy2 <= 1'b0;
        end else if (uart_tx_en2) begin
            bcnt2 <= 9; uart_tx_busy2 <= 1'b1;
        end else if (bcnt2 != 0) begin
            bcnt2 <= bcnt2 - 1;
        end else begin
            uart_tx_busy2 <= 1'b0;
        end
    end

    // Scoreboard: every strobe pops one expected character.
    always @(negedge CLK) begin
        logic [7:0] e;
        if (uart_tx_en) begin
            strobes++;
            checks++;
            if (uart_tx_busy) begin
                failures++;
                $display("FAIL strobe_while_busy: busy=%0b required=0", uart_tx_busy);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: data=%h required=no strobe", uart_tx_data);
            end else begin
                e = exp_q.pop_front();
                if (uart_tx_data !== e) begin
                    failures++;
                    $display("FAIL tx_char: data=%h required=%h", uart_tx_data, e);
                end
            end
        end
        if (uart_tx_en2) begin
            strobes2++;
            checks++;
            if (exp_q2.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe19: data=%h required=no strobe", uart_tx_data2);
            end else begin
                e = exp_q2.pop_front();
                if (uart_tx_data2 !== e) begin
                    failures++;
                    $display("FAIL tx_char19: data=%h required=%h", uart_tx_data2, e);
                end
            end
        end
        if (gonderim_bitti)  bitti_cnt++;
        if (gonderim_bitti2) bitti_cnt2++;
    end

    task automatic set_time(input int g, input int a, input int y, input int h, input int m, input int s);
        gun = 5'(g); ay = 4'(a); yil = 12'(y); saat = 5'(h); dakika = 6'(m); saniye = 6'(s);
    endtask

    task automatic push_msg(input int which, input int g, input int a, input int y,
                            input int h, input int m, input int s, input bit crlf);
        logic [7:0] msg[$];
        msg.push_back(8'(48 + g / 10));  msg.push_back(8'(48 + g % 10));  msg.push_back(8'h2E);
        msg.push_back(8'(48 + a / 10));  msg.push_back(8'(48 + a % 10));  msg.push_back(8'h2E);
        msg.push_back(8'(48 + y / 1000)); msg.push_back(8'(48 + (y / 100) % 10));
        msg.push_back(8'(48 + (y / 10) % 10)); msg.push_back(8'(48 + y % 10));
        msg.push_back(8'h20);
        msg.push_back(8'(48 + h / 10));  msg.push_back(8'(48 + h % 10));  msg.push_back(8'h3A);
        msg.push_back(8'(48 + m / 10));  msg.push_back(8'(48 + m % 10));  msg.push_back(8'h3A);
        msg.push_back(8'(48 + s / 10));  msg.push_back(8'(48 + s % 10));
        if (crlf) begin
            msg.push_back(8'h0D); msg.push_back(8'h0A);
        end
        foreach (msg[i]) begin
            if (which == 0) exp_q.push_back(msg[i]);
            else            exp_q2.push_back(msg[i]);
        end
    endtask

    // Valid held for the single cycle between two falling edges; returns at the second one.
    task automatic send_cmd(input int which, input logic [7:0] b);
        @(negedge CLK);
        uart_rx_data = b;
        if (which == 0) uart_rx_valid = 1'b1; else uart_rx_valid2 = 1'b1;
        @(negedge CLK);
        uart_rx_valid = 1'b0; uart_rx_valid2 = 1'b0;
    endtask

    task automatic wait_bitti(input int which, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge CLK);
            if ((which == 0 && gonderim_bitti) || (which == 1 && gonderim_bitti2)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (uart_tx_en !== 1'b0 || uart_tx_data !== 8'h00 || mesgul !== 1'b0 || gonderim_bitti !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: en=%b data=%h mesgul=%b bitti=%b required=0 00 0 0",
                     uart_tx_en, uart_tx_data, mesgul, gonderim_bitti);
        end
        checks++;
        if (uart_tx_en2 !== 1'b0 || uart_tx_data2 !== 8'h00 || mesgul2 !== 1'b0 || gonderim_bitti2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state19: en=%b data=%h mesgul=%b bitti=%b required=0 00 0 0",
                     uart_tx_en2, uart_tx_data2, mesgul2, gonderim_bitti2);
        end
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_basic;
        int s0, b0;
        bit ok;
        set_time(30, 7, 2024, 18, 30, 5);
        push_msg(0, 30, 7, 2024, 18, 30, 5, 1'b1);
        s0 = strobes; b0 = bitti_cnt;
        send_cmd(0, 8'h54);
        checks++;
        if (mesgul !== 1'b1) begin
            failures++;
            $display("FAIL mesgul_n1: mesgul=%b required=1", mesgul);
        end
        @(negedge CLK);
        checks++;
        if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h33) begin
            failures++;
            $display("FAIL first_strobe_n2: en=%b data=%h required=1 33", uart_tx_en, uart_tx_data);
        end
        wait_bitti(0, 600, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_timeout: bitti=0 required=1");
        end
        checks++;
        if (mesgul !== 1'b0) begin
            failures++;
            $display("FAIL mesgul_at_bitti: mesgul=%b required=0", mesgul);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (strobes - s0 != 21 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_count: strobes=%0d left=%0d required=21 0", strobes - s0, exp_q.size());
        end
        checks++;
        if (bitti_cnt - b0 != 1) begin
            failures++;
            $display("FAIL basic_bitti_pulses: got=%0d required=1", bitti_cnt - b0);
        end
    endtask

    task automatic test_non_command;
        logic [7:0] bytes_in [3];
        bit bad;
        bytes_in[0] = 8'h47; bytes_in[1] = 8'h74; bytes_in[2] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            bad = 1'b0;
            send_cmd(0, bytes_in[k]);
            for (int i = 0; i < 5; i++) begin
                if (uart_tx_en !== 1'b0 || mesgul !== 1'b0) bad = 1'b1;
                @(negedge CLK);
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL non_command_%h: reacted=1 required=0", bytes_in[k]);
            end
        end
    endtask

    task automatic test_snapshot;
        bit ok;
        set_time(30, 7, 2024, 18, 30, 5);
        push_msg(0, 30, 7, 2024, 18, 30, 5, 1'b1);
        send_cmd(0, 8'h54);
        repeat (40) @(negedge CLK);
        saniye = 6'd6;
        wait_bitti(0, 600, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            failures++;
            $display("FAIL snapshot_done: ok=%0b left=%0d required=1 0", ok, exp_q.size());
        end
        saniye = 6'd5;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_ignored_repeat;
        int s0;
        bit ok;
        push_msg(0, 30, 7, 2024, 18, 30, 5, 1'b1);
        s0 = strobes;
        send_cmd(0, 8'h54);
        repeat (30) @(negedge CLK);
        send_cmd(0, 8'h54);
        wait_bitti(0, 600, ok);
        repeat (30) @(negedge CLK);
        checks++;
        if (!ok || strobes - s0 != 21 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ignored_repeat: ok=%0b strobes=%0d left=%0d required=1 21 0",
                     ok, strobes - s0, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        push_msg(0, 30, 7, 2024, 18, 30, 5, 1'b1);
        send_cmd(0, 8'h54);
        wait_bitti(0, 600, ok);
        // Command during the completion pulse must be ignored.
        uart_rx_data = 8'h54; uart_rx_valid = 1'b1;
        @(negedge CLK);
        checks++;
        if (!ok || mesgul !== 1'b0) begin
            failures++;
            $display("FAIL cmd_during_bitti: ok=%0b mesgul=%b required=1 0", ok, mesgul);
        end
        push_msg(0, 30, 7, 2024, 18, 30, 5, 1'b1);
        @(negedge CLK);
        uart_rx_valid = 1'b0;
        checks++;
        if (mesgul !== 1'b1) begin
            failures++;
            $display("FAIL cmd_after_bitti: mesgul=%b required=1", mesgul);
        end
        wait_bitti(0, 600, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            failures++;
            $display("FAIL back_to_back_done: ok=%0b left=%0d required=1 0", ok, exp_q.size());
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset_abort;
        int s0;
        bit seen;
        bit ok;
        push_msg(0, 30, 7, 2024, 18, 30, 5, 1'b1);
        s0 = strobes;
        seen = 1'b0;
        send_cmd(0, 8'h54);
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge CLK);
            #1;
            if (strobes - s0 == 7) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL abort_7th_strobe: strobes=%0d required=7", strobes - s0);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (uart_tx_en !== 1'b0 || mesgul !== 1'b0 || uart_tx_data !== 8'h00) begin
            failures++;
            $display("FAIL abort_immediate: en=%b mesgul=%b data=%h required=0 0 00",
                     uart_tx_en, mesgul, uart_tx_data);
        end
        exp_q.delete();
        s0 = strobes;
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        repeat (5) @(negedge CLK);
        checks++;
        if (strobes != s0) begin
            failures++;
            $display("FAIL abort_no_strobes: strobes=%0d required=0", strobes - s0);
        end
        push_msg(0, 30, 7, 2024, 18, 30, 5, 1'b1);
        send_cmd(0, 8'h54);
        wait_bitti(0, 600, ok);
        repeat (2) @(negedge CLK);
        checks++;
        if (!ok || strobes - s0 != 21 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_restart: ok=%0b strobes=%0d left=%0d required=1 21 0",
                     ok, strobes - s0, exp_q.size());
        end
    endtask

    task automatic test_satir_sonu_off;
        int s0;
        bit ok;
        set_time(30, 7, 5, 18, 30, 5);
        push_msg(1, 30, 7, 5, 18, 30, 5, 1'b0);
        s0 = strobes2;
        send_cmd(1, 8'h54);
        wait_bitti(1, 600, ok);
        repeat (2) @(negedge CLK);
        checks++;
        if (!ok || strobes2 - s0 != 19 || exp_q2.size() != 0) begin
            failures++;
            $display("FAIL satir_sonu_off: ok=%0b strobes=%0d left=%0d required=1 19 0",
                     ok, strobes2 - s0, exp_q2.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        uart_rx_valid = 1'b0;
        uart_rx_valid2 = 1'b0;
        uart_rx_data = 8'h00;
        set_time(30, 7, 2024, 18, 30, 5);
        test_reset();
        test_basic();
        test_non_command();
        test_snapshot();
        test_ignored_repeat();
        test_back_to_back();
        test_reset_abort();
        test_satir_sonu_off();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
